banked_mem_responder: RTL and testbench



---
 rtl/banked_mem_responder_if.sv | 33 +++
 rtl/banked_mem_responder.sv | 103 ++++++++++
 tb/tb_banked_mem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/banked_mem_responder_if.sv
// banked_mem_responder_if
//
// Request/response bundle between the cache controller (master) and the
// banked main-memory model (slave).
//
//   Addr    master->slave  16-bit byte address (bit 0 must be 0)
//   DataIn  master->slave  16-bit write data
//   wr      master->slave  write request
//   rd      master->slave  read request
//   DataOut slave->master  read data, nonzero only in the return cycle
//   stall   slave->master  request hit a busy bank and was dropped
//   busy    slave->master  per-bank busy flags
//   err     slave->master  request was illegal and was dropped
interface banked_mem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        wr;
  logic        rd;
  logic [15:0] DataOut;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output Addr, DataIn, wr, rd,
    input  DataOut, stall, busy, err
  );

  modport slave (
    input  Addr, DataIn, wr, rd,
    output DataOut, stall, busy, err
  );
endinterface

// File: rtl/banked_mem_responder.sv
// banked_mem_responder
//
// Four-bank, word-interleaved main-memory model. Consecutive 16-bit words
// land in consecutive banks, so a controller streaming words 0..3 never
// conflicts. Each bank is busy for three cycles after an accepted access,
// and read data comes back exactly two cycles after the accepting edge.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears busy counters and the
//          read pipe; the storage array keeps its contents)
//   bus    slave side of banked_mem_responder_if
//
// Parameter:
//   ROW_BITS  row index width per bank; each bank holds 2**ROW_BITS words
module banked_mem_responder #(
  parameter int ROW_BITS = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  banked_mem_responder_if.slave  bus
);

  localparam int WORDS = 4 << ROW_BITS;

  logic [1:0]          bank_sel;
  logic [ROW_BITS-1:0] row_sel;
  logic [ROW_BITS+1:0] word_idx;
  logic                req_legal;
  logic                accept;
  logic [3:0]          busy_vec;

  logic [1:0]  cnt [4];
  logic [15:0] mem [WORDS];

  logic        s1_valid;
  logic        s2_valid;
  logic [15:0] s1_data;
  logic [15:0] s2_data;

  assign bank_sel = bus.Addr[2:1];
  assign row_sel  = bus.Addr[ROW_BITS+2:3];
  // Bank in the low bits gives the word interleave in a single flat array.
  assign word_idx = {row_sel, bank_sel};

  assign req_legal = (bus.rd ^ bus.wr) & ~bus.Addr[0];
  assign accept    = req_legal & ~busy_vec[bank_sel];

  // rd^wr inside req_legal already keeps stall low for a rd+wr collision.
  assign bus.err   = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.Addr[0]);
  assign bus.stall = req_legal & busy_vec[bank_sel];
  assign bus.busy  = busy_vec;

  always_comb begin
    busy_vec = '0;
    for (int b = 0; b < 4; b++) begin
      busy_vec[b] = (cnt[b] != 2'd0);
    end
  end

  // Loading 3 on accept keeps the bank busy for the next three cycles, so it
  // can accept again four cycles after the previous access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        cnt[b] <= 2'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank_sel == 2'(b))) begin
          cnt[b] <= 2'd3;
        end else if (cnt[b] != 2'd0) begin
          cnt[b] <= cnt[b] - 2'd1;
        end
      end
    end
  end

  // Only the valid bits are reset: dropping them discards in-flight reads
  // while the data path and array stay reset-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept & bus.rd;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      mem[word_idx] <= bus.DataIn;
    end
    if (accept && bus.rd) begin
      s1_data <= mem[word_idx];
    end
    s2_data <= s1_data;
  end

  assign bus.DataOut = s2_valid ? s2_data : 16'h0000;

endmodule

// File: tb/tb_banked_mem_responder.sv
// tb_banked_mem_responder
//
// Directed bench for banked_mem_responder. Each step drives one cycle of
// request inputs just after a rising edge, compares DataOut/stall/busy/err
// on the following falling edge against hand-computed values, and then
// advances to just after the next rising edge (the accepting edge).
module tb_banked_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  banked_mem_responder_if bus ();

  banked_mem_responder #(.ROW_BITS(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point shared by every check.
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic rd_i, input logic wr_i,
                               input logic [15:0] addr_i, input logic [15:0] data_i);
    bus.rd     = rd_i;
    bus.wr     = wr_i;
    bus.Addr   = addr_i;
    bus.DataIn = data_i;
  endtask

  task automatic checkOutput(input string label, input logic [15:0] e_dout,
                             input logic e_stall, input logic [3:0] e_busy,
                             input logic e_err);
    chk({label, ".dout"},  bus.DataOut,          e_dout);
    chk({label, ".stall"}, {15'd0, bus.stall},   {15'd0, e_stall});
    chk({label, ".busy"},  {12'd0, bus.busy},    {12'd0, e_busy});
    chk({label, ".err"},   {15'd0, bus.err},     {15'd0, e_err});
  endtask

  // One cycle: drive, check on the falling edge, move past the rising edge.
  task automatic step(input string label, input logic rd_i, input logic wr_i,
                      input logic [15:0] addr_i, input logic [15:0] data_i,
                      input logic [15:0] e_dout, input logic e_stall,
                      input logic [3:0] e_busy, input logic e_err);
    applyStimulus(rd_i, wr_i, addr_i, data_i);
    @(negedge clk);
    checkOutput(label, e_dout, e_stall, e_busy, e_err);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string label, input logic [15:0] e_dout, input logic [3:0] e_busy);
    step(label, 1'b0, 1'b0, 16'h0000, 16'h0000, e_dout, 1'b0, e_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    idle("reset", 16'h0000, 4'b0000);
    rst_n = 1'b1;

    // Sequential-bank write stream, then read stream.
    $display("[TB] streaming writes and reads across banks 0-3");
    step("w0", 1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0, 4'b0000, 1'b0);
    step("w1", 1'b0, 1'b1, 16'h0002, 16'h2222, 16'h0000, 1'b0, 4'b0001, 1'b0);
    step("w2", 1'b0, 1'b1, 16'h0004, 16'h3333, 16'h0000, 1'b0, 4'b0011, 1'b0);
    step("w3", 1'b0, 1'b1, 16'h0006, 16'h4444, 16'h0000, 1'b0, 4'b0111, 1'b0);
    step("r0", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'b1110, 1'b0);
    step("r1", 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 4'b1101, 1'b0);
    step("r2", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1111, 1'b0, 4'b1011, 1'b0);
    step("r3", 1'b1, 1'b0, 16'h0006, 16'h0000, 16'h2222, 1'b0, 4'b0111, 1'b0);
    idle("s8",  16'h3333, 4'b1110);
    idle("s9",  16'h4444, 4'b1100);
    idle("s10", 16'h0000, 4'b1000);
    idle("s11", 16'h0000, 4'b0000);

    // Same-bank conflict: bank 0 rows 1 and 2.
    $display("[TB] same-bank conflict");
    step("cw0", 1'b0, 1'b1, 16'h0008, 16'hA008, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("ci1", 16'h0000, 4'b0001);
    idle("ci2", 16'h0000, 4'b0001);
    idle("ci3", 16'h0000, 4'b0001);
    step("cw1", 1'b0, 1'b1, 16'h0010, 16'hB010, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("ci5", 16'h0000, 4'b0001);
    idle("ci6", 16'h0000, 4'b0001);
    idle("ci7", 16'h0000, 4'b0001);
    step("ct0", 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    step("ct1", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 4'b0001, 1'b0);
    step("ct2", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hA008, 1'b1, 4'b0001, 1'b0);
    step("ct3", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 4'b0001, 1'b0);
    step("ct4", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("ct5", 16'h0000, 4'b0001);
    idle("ct6", 16'hB010, 4'b0001);
    idle("ct7", 16'h0000, 4'b0001);
    idle("ct8", 16'h0000, 4'b0000);

    // Illegal requests, including one in the cycle bank 1 frees up.
    $display("[TB] illegal requests");
    step("ew0", 1'b0, 1'b1, 16'h000A, 16'h0A0A, 16'h0000, 1'b0, 4'b0000, 1'b0);
    step("e1",  1'b1, 1'b1, 16'h0002, 16'hDEAD, 16'h0000, 1'b0, 4'b0010, 1'b1);
    step("e2",  1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0, 4'b0010, 1'b1);
    step("e3",  1'b1, 1'b1, 16'h0002, 16'hDEAD, 16'h0000, 1'b0, 4'b0010, 1'b1);
    step("e4",  1'b1, 1'b1, 16'h000A, 16'hDEAD, 16'h0000, 1'b0, 4'b0000, 1'b1);
    step("e5",  1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("e6", 16'h0000, 4'b0010);
    idle("e7", 16'h2222, 4'b0010);
    idle("e8", 16'h0000, 4'b0010);
    step("e9",  1'b1, 1'b0, 16'h000A, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("e10", 16'h0000, 4'b0010);
    idle("e11", 16'h0A0A, 4'b0010);
    idle("e12", 16'h0000, 4'b0010);
    idle("e13", 16'h0000, 4'b0000);

    // Read-after-write to a busy bank (0x00A4 is bank 2).
    $display("[TB] read-after-write retry");
    step("b0", 1'b0, 1'b1, 16'h00A4, 16'hBEEF, 16'h0000, 1'b0, 4'b0000, 1'b0);
    step("b1", 1'b1, 1'b0, 16'h00A4, 16'h0000, 16'h0000, 1'b1, 4'b0100, 1'b0);
    idle("b2", 16'h0000, 4'b0100);
    idle("b3", 16'h0000, 4'b0100);
    step("b4", 1'b1, 1'b0, 16'h00A4, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("b5", 16'h0000, 4'b0100);
    idle("b6", 16'hBEEF, 4'b0100);
    idle("b7", 16'h0000, 4'b0100);
    idle("b8", 16'h0000, 4'b0000);

    // Reset while a read is in flight.
    $display("[TB] reset mid-operation");
    step("x0", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b0;
    idle("x1", 16'h0000, 4'b0000);
    idle("x2", 16'h0000, 4'b0000);
    rst_n = 1'b1;
    step("x3", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("x4", 16'h0000, 4'b0100);
    idle("x5", 16'h3333, 4'b0100);
    idle("x6", 16'h0000, 4'b0100);
    idle("x7", 16'h0000, 4'b0000);

    // Overwrite, top row of bank 3, and no clobbering of bank 3 row 0.
    $display("[TB] overwrite and top-row access");
    step("g0", 1'b0, 1'b1, 16'h0002, 16'h5A5A, 16'h0000, 1'b0, 4'b0000, 1'b0);
    step("g1", 1'b0, 1'b1, 16'hFFFE, 16'hC3C3, 16'h0000, 1'b0, 4'b0010, 1'b0);
    idle("g2", 16'h0000, 4'b1010);
    idle("g3", 16'h0000, 4'b1010);
    step("g4", 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 4'b1000, 1'b0);
    step("g5", 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 4'b0010, 1'b0);
    step("g6", 1'b1, 1'b0, 16'h0006, 16'h0000, 16'h5A5A, 1'b1, 4'b1010, 1'b0);
    idle("g7", 16'hC3C3, 4'b1010);
    idle("g8", 16'h0000, 4'b1000);
    step("g9", 1'b1, 1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    idle("g10", 16'h0000, 4'b1000);
    idle("g11", 16'h4444, 4'b1000);
    idle("g12", 16'h0000, 4'b1000);
    idle("g13", 16'h0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
